// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 access sizes,
// FSM states, the latched request record and the size decoder.
package dmem_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = $clog2(NUM_LANES);

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_e;

    typedef struct packed {
        logic [31:0]               addr;
        logic                      we;
        logic [2:0]                funct3;
        logic [NUM_LANES-1:0][7:0] wdata;
    } req_t;

    // Access width in bytes; 0 flags an undefined funct3.
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            F3_W:        return 3'd4;
            default:     return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the execute stage (master) and the
// data-memory responder (slave).
interface dmem_if;
    import dmem_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic [31:0]               req_addr;
    logic                      req_we;
    logic [2:0]                req_funct3;
    logic [NUM_LANES-1:0][7:0] req_wdata;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [NUM_LANES-1:0][7:0] rsp_rdata;
    logic                      rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_byte_array.sv
// Four byte-wide banks; lane i of an access hits byte address addr+i, so an
// unaligned access rotates its lanes across banks and may span two rows.
module dmem_bank #(
    parameter int ROWS = 1024,
    parameter int RW   = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [RW-1:0] row,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (we) mem[row] <= wdata;
    end

    assign rdata = mem[row];

endmodule

module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 4096
) (
    input  logic                            clk,
    input  logic [$clog2(DEPTH_BYTES)-1:0]  addr,
    input  logic [NUM_LANES-1:0]            we,
    input  logic [NUM_LANES-1:0][7:0]       wdata,
    output logic [NUM_LANES-1:0][7:0]       rdata
);
    localparam int AW   = $clog2(DEPTH_BYTES);
    localparam int ROWS = DEPTH_BYTES / NUM_LANES;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [NUM_LANES-1:0][7:0] bank_rdata;

    for (genvar b = 0; b < NUM_LANES; b++) begin : g_bank
        logic [LANE_W-1:0] lane;
        logic [AW-1:0]     byte_addr;

        // Which request lane lands in this bank, and at which row.
        assign lane      = LANE_W'(b) - addr[LANE_W-1:0];
        assign byte_addr = addr + AW'(lane);

        dmem_bank #(.ROWS(ROWS), .RW(RW)) u_bank (
            .clk   (clk),
            .we    (we[lane]),
            .row   (RW'(byte_addr >> LANE_W)),
            .wdata (wdata[lane]),
            .rdata (bank_rdata[b])
        );
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_LANES; i++)
            rdata[i] = bank_rdata[LANE_W'(addr[LANE_W-1:0] + LANE_W'(i))];
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned H/HU/W accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);
    localparam int AW = $clog2(DEPTH_BYTES);

    state_e                    state, state_n;
    req_t                      req_q;
    logic [3:0]                cnt;
    logic                      rsp_err_q;
    logic [NUM_LANES-1:0][7:0] rsp_rdata_q, mem_rdata, rdata_n;
    logic [2:0]                n_bytes;
    logic                      f3_bad, range_bad, misalign, err;
    logic [NUM_LANES-1:0]      lane_en, mem_we;

    // Checks run on the latched request; range uses 33 bits so it never wraps.
    always_comb begin
        n_bytes   = size_bytes(req_q.funct3);
        f3_bad    = (n_bytes == 3'd0);
        range_bad = ({1'b0, req_q.addr} + 33'(n_bytes)) > 33'(DEPTH_BYTES);
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign  = (n_bytes == 3'd2 && req_q.addr[0]) ||
                    (n_bytes == 3'd4 && req_q.addr[1:0] != 2'b00);
`else
        misalign  = 1'b0;
`endif
        err       = f3_bad | range_bad | misalign;

        lane_en = '0;
        for (int i = 0; i < NUM_LANES; i++)
            lane_en[i] = (i < int'(n_bytes));

        // A reset landing on the ACCESS edge must not leave partial lanes.
        mem_we = (state == ACCESS && req_q.we && !err && !rst) ? lane_en : '0;

        rdata_n = '0;
        for (int i = 0; i < NUM_LANES; i++)
            if (lane_en[i] && !req_q.we && !err) rdata_n[i] = mem_rdata[i];
    end

    always_comb begin
        state_n       = state;
        bus.req_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = !rst;
                if (bus.req_valid) state_n = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
            end
            WAIT:    if (cnt == 4'd0) state_n = ACCESS;
            ACCESS:  state_n = RESP;
            RESP:    if (bus.rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_q <= '{addr:   bus.req_addr,
                                   we:     bus.req_we,
                                   funct3: bus.req_funct3,
                                   wdata:  bus.req_wdata};
                        cnt   <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
                    end
                end
                WAIT: cnt <= cnt - 4'd1;
                ACCESS: begin
                    rsp_err_q   <= err;
                    rsp_rdata_q <= rdata_n;
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    dmem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
        .clk   (clk),
        .addr  (req_q.addr[AW-1:0]),
        .we    (mem_we),
        .wdata (req_q.wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: a byte-array model predicts every
// response, a negedge monitor checks handshake timing and data each cycle.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 4096;
    localparam int W     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dmem_if bus ();

    dmem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [7:0]  mem_m [DEPTH];
    bit          busy = 1'b0;
    bit          seen = 1'b0;
    int          acc_cyc;
    logic [31:0] cur_a, cur_wd, exp_rd;
    logic [2:0]  cur_f3;
    bit          cur_we, exp_err;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void timeout_fail(string name);
        n_chk++;
        $display("FAIL timeout %s: no handshake within bound (cycle %0d)", name, cyc);
    endfunction

    // Reference behaviour: the access happens as one indivisible step.
    function automatic void model_resp();
        int n;
        case (cur_f3)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            3'd2:       n = 4;
            default:    n = 0;
        endcase
        exp_err = (n == 0) || (longint'(cur_a) + n > DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((n == 2 && cur_a[0]) || (n == 4 && cur_a[1:0] != 2'b00)) exp_err = 1'b1;
`endif
        exp_rd = '0;
        if (!exp_err)
            for (int i = 0; i < n; i++)
                if (cur_we) mem_m[int'(cur_a) + i] = cur_wd[8*i +: 8];
                else        exp_rd[8*i +: 8] = mem_m[int'(cur_a) + i];
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("req_ready_in_reset", bus.req_ready, 0);
            busy = 1'b0;
            seen = 1'b0;
        end else if (!busy) begin
            chk("req_ready_idle", bus.req_ready, 1);
            chk("rsp_valid_idle", bus.rsp_valid, 0);
            if (bus.req_valid) begin
                busy    = 1'b1;
                seen    = 1'b0;
                cur_a   = bus.req_addr;
                cur_we  = bus.req_we;
                cur_f3  = bus.req_funct3;
                cur_wd  = bus.req_wdata;
                acc_cyc = cyc;
            end
        end else begin
            chk("req_ready_busy", bus.req_ready, 0);
            if (!seen) begin
                chk("rsp_valid_latency", bus.rsp_valid, 32'(cyc - acc_cyc >= W + 2));
                if (bus.rsp_valid) begin
                    seen = 1'b1;
                    model_resp();
                end
            end
            if (seen) begin
                chk("rsp_valid_held", bus.rsp_valid, 1);
                chk("rsp_rdata", bus.rsp_rdata, exp_rd);
                chk("rsp_err", bus.rsp_err, exp_err);
                if (bus.rsp_ready) busy = 1'b0;
            end
        end
    end

    task automatic xact(input logic [31:0] a, input bit we, input logic [2:0] f3,
                        input logic [31:0] wd, input int stall,
                        output logic [31:0] rd, output bit er);
        int t;
        rd = '0;
        er = 1'b0;
        bus.req_addr   = a;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        bus.rsp_ready  = (stall == 0);
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.req_ready && t < 100);
        if (!bus.req_ready) begin
            timeout_fail("accept");
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Junk while busy: the responder must neither accept nor latch it.
        bus.req_valid  = 1'($urandom_range(0, 1));
        bus.req_addr   = $urandom;
        bus.req_we     = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_wdata  = $urandom;
        repeat (W + 1) @(posedge clk);
        #1 bus.req_valid = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.rsp_valid && t < 100);
        if (!bus.rsp_valid) begin
            timeout_fail("response");
            return;
        end
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            @(posedge clk); #1 bus.rsp_ready = 1'b1;
            @(negedge clk);
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a;
        logic [2:0]  f3;
        bit          er;
        int          t, r;

        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", bus.req_ready, 1);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_err", bus.rsp_err, 0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 0);
        @(posedge clk); #1;

        // Fill the whole array so every later read has a known model value.
        for (int i = 0; i < DEPTH; i += 4) xact(i, 1'b1, F3_W, $urandom, 0, rd, er);

        xact(32'h10, 1'b1, F3_W, 32'hDEADBEEF, 0, rd, er);
        chk("sw_0x10_err", er, 0);
        xact(32'h10, 1'b0, F3_W, 32'h0, 0, rd, er);
        chk("lw_0x10_data", rd, 32'hDEADBEEF);
        xact(32'h11, 1'b1, F3_B, 32'h00000055, 0, rd, er);
        xact(32'h10, 1'b0, F3_W, 32'h0, 0, rd, er);
        chk("sb_keeps_neighbours", rd, 32'hDEAD55EF);

        xact(32'hFFC, 1'b0, F3_W, 32'h0, 0, rd, er);
        chk("lw_0xffc_err", er, 0);
        xact(32'hFFD, 1'b0, F3_W, 32'h0, 0, rd, er);
        chk("lw_0xffd_err", er, 1);
        chk("lw_0xffd_rdata", rd, 0);
        xact(32'h1000, 1'b1, F3_B, 32'h000000A5, 0, rd, er);
        chk("sb_0x1000_err", er, 1);
        xact(32'h8000_0010, 1'b0, F3_W, 32'h0, 0, rd, er);
        chk("lw_high_addr_err", er, 1);
        xact(32'h20, 1'b0, 3'd3, 32'h0, 0, rd, er);
        chk("funct3_3_err", er, 1);
        chk("funct3_3_rdata", rd, 0);

        xact(32'h20, 1'b1, F3_W, 32'h44332211, 0, rd, er);
        xact(32'h21, 1'b0, F3_H, 32'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lh_0x21_trap_err", er, 1);
`else
        chk("lh_0x21_err", er, 0);
        chk("lh_0x21_data", rd, 32'h00003322);
`endif

        xact(32'h10, 1'b0, F3_W, 32'h0, 10, rd, er);
        chk("stalled_lw_data", rd, 32'hDEAD55EF);

        // Reset during WAIT of a store must drop it entirely.
        xact(32'h40, 1'b1, F3_W, 32'h11111111, 0, rd, er);
        bus.req_addr   = 32'h40;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_wdata  = 32'hAAAAAAAA;
        bus.req_valid  = 1'b1;
        bus.rsp_ready  = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.req_ready && t < 100);
        if (!bus.req_ready) timeout_fail("reset_store_accept");
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.rsp_ready = 1'b0;
        xact(32'h40, 1'b0, F3_W, 32'h0, 0, rd, er);
        chk("reset_drops_store", rd, 32'h11111111);

        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = DEPTH - 4 + $urandom_range(0, 7);
            else             a = $urandom_range(0, DEPTH - 1);
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    f3 = F3_B;
                2:       f3 = F3_BU;
                3, 4:    f3 = F3_H;
                5:       f3 = F3_HU;
                6, 7, 8: f3 = F3_W;
                default: f3 = 3'($urandom_range(0, 7));
            endcase
            xact(a, 1'($urandom_range(0, 1)), f3, $urandom, $urandom_range(0, 3), rd, er);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
